dmem_sized_ctrl: RTL and testbench

Parametrised, clocked successor to the single-cycle data memory. It serves RISC-V load/store requests through a valid/ready request port and a one-cycle response pulse. It supports byte, half and word accesses with sign or zero extension, a configurable number of wait states, and error reporting for misaligned, out-of-range or illegal accesses. It sits between the core's memory stage and the word-organised data array.

---
 rtl/dmem_sized_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dmem_sized_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized_ctrl.sv
// dmem_sized_ctrl: clocked data memory controller for RISC-V loads and stores.
// It accepts one request at a time on a valid/ready port. After WAIT_CYCLES busy cycles it
// performs a byte, half or word access on a word-organised array. It then returns a
// one-cycle response pulse.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset (array contents untouched)
//   req_valid  - request present
//   req_ready  - controller idle and able to accept
//   req_we     - 1 = store, 0 = load
//   req_funct3 - RISC-V funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   req_addr   - byte address
//   req_wdata  - right-aligned store data
//   rsp_valid  - one-cycle response pulse
//   rsp_rdata  - load result, 0 for stores and errors
//   rsp_err    - request rejected without touching the array
module dmem_sized_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned INIT_MODE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AddrW = IdxW + 2;
    localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic              req_bad;
    logic              wr_en;
    logic [IdxW-1:0]   wr_idx;
    logic [31:0]       rd_word, wr_mask, wr_lanes, wr_word, load_data;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       mem_rd [DEPTH];

    // Legality is decided on the live request so the error path never enters BUSY.
    always_comb begin
        req_bad = 1'b0;
        if (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7) req_bad = 1'b1;
        if (req_we && req_funct3[2]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'd1 && req_addr[0]) req_bad = 1'b1;
        if (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) req_bad = 1'b1;
        if ({2'b00, req_addr[31:2]} >= DEPTH) req_bad = 1'b1;
    end

    assign wr_idx  = addr_q[AddrW-1:2];
    assign rd_word = mem_rd[wr_idx];

    // Store merge: replicate the data into every lane, then keep only the selected bytes.
    always_comb begin
        case (funct3_q[1:0])
            2'd0: begin
                wr_mask  = 32'h0000_00ff << {addr_q[1:0], 3'b000};
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                wr_mask  = addr_q[1] ? 32'hffff_0000 : 32'h0000_ffff;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_mask  = 32'hffff_ffff;
                wr_lanes = wdata_q;
            end
        endcase
        wr_word = (rd_word & ~wr_mask) | (wr_lanes & wr_mask);
    end

    always_comb begin
        rd_byte = 8'(rd_word >> {addr_q[1:0], 3'b000});
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3_q)
            3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_data = {24'd0, rd_byte};
            3'd5:    load_data = {16'd0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        wr_en       = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    addr_d      = req_addr[AddrW-1:0];
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (req_bad) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = WaitCnt;
                    end
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    wr_en       = we_q;
                    rsp_rdata_d = we_q ? 32'd0 : load_data;
                end
            end
            StResp: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array words: contents come from the declaration value at time zero and are never reset,
    // so an abort by rst (which clears state_q and hence wr_en) leaves memory untouched.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [31:0] word_q = (INIT_MODE != 0) ? 32'(i * 10) : 32'd0;
        always_ff @(posedge clk) begin
            if (wr_en && wr_idx == IdxW'(i)) begin
                word_q <= wr_word;
            end
        end
        assign mem_rd[i] = word_q;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Bench for dmem_sized_ctrl: two instances (WAIT_CYCLES 1 and 3) driven by directed and random
// requests; a scoreboard queue holds expected responses, popped by a negedge monitor.
module tb_dmem_sized_ctrl;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic [1:0]        rst;
    logic [1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [1:0][2:0]   req_funct3;
    logic [1:0][31:0]  req_addr, req_wdata, rsp_rdata;

    int          wc [2] = '{1, 3};
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          acc_cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [2][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_sized_ctrl #(
            .DEPTH(1024),
            .WAIT_CYCLES(g == 0 ? 1 : 3),
            .INIT_MODE(1)
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we(req_we[g]),
            .req_funct3(req_funct3[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err(rsp_err[g])
        );
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: byte-granular view of each word, built directly from the access rules.
    task automatic ref_access(input int d, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input bit commit,
                              output logic [31:0] rdata, output logic err);
        int size, lane;
        logic [31:0] idx, v;
        idx  = addr >> 2;
        lane = int'(addr % 4);
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        err  = (f3 == 3) || (f3 > 5) || (we && f3 > 3) || (size == 2 && addr % 2 != 0) ||
               (size == 4 && lane != 0) || (idx >= 1024);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                if (commit)
                    for (int k = 0; k < size; k++)
                        model[d][idx][8*(lane+k) +: 8] = wdata[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < size; k++) v[8*k +: 8] = model[d][idx][8*(lane+k) +: 8];
                if (f3 < 4 && size < 4 && v[8*size-1]) v = v | (32'hffff_ffff << (8*size));
                rdata = v;
            end
        end
    endtask

    // Issue one request; when use_lit is set the literal expectation replaces the model's.
    task automatic do_req(input int d, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit hold, input bit use_lit,
                          input logic [31:0] lit_rd, input logic lit_err, input bit commit);
        int n;
        exp_t e;
        logic [31:0] rd;
        logic er;
        n = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: dut%0d req_ready stayed %b, required 1", d, req_ready[d]);
        end
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_valid[d]  = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        check("accept_ready_low", {31'd0, req_ready[d]}, 32'd0);
        if (!hold) req_valid[d] = 1'b0;
        ref_access(d, we, f3, addr, wdata, commit, rd, er);
        if (use_lit) begin
            rd = lit_rd;
            er = lit_err;
        end
        if (commit) begin
            e.dut   = d;
            e.rdata = rd;
            e.err   = er;
            e.due   = er ? acc_cyc : acc_cyc + wc[d] + 1;
            sb.push_back(e);
        end
    endtask

    task automatic rand_req(input int d);
        logic [31:0] a;
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) begin
            if ($urandom_range(0, 1) == 1) a = $urandom() | 32'h8000_0000;
            else a = ((32'd1024 + 32'($urandom_range(0, 7))) << 2) | 32'($urandom_range(0, 3));
        end else if (sel == 1) begin
            a = (32'($urandom_range(1020, 1023)) << 2) | 32'($urandom_range(0, 3));
        end else begin
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        end
        do_req(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
               1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                check("rsp_ready_low", {31'd0, req_ready[d]}, 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: dut%0d pulsed with rdata %h, required no pulse",
                             d, rsp_rdata[d]);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_dut", 32'(d), 32'(mon_e.dut));
                    check("rsp_rdata", rsp_rdata[d], mon_e.rdata);
                    check("rsp_err", {31'd0, rsp_err[d]}, {31'd0, mon_e.err});
                    check("rsp_cycle", 32'(cyc), 32'(mon_e.due));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) model[d][i] = 32'(i * 10);
        rst        = 2'b11;
        req_valid  = '0;
        req_we     = '0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", {31'd0, req_ready[d]}, 32'd1);
            check("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check("reset_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
        end
        rst = 2'b00;

        // Directed traffic on the WAIT_CYCLES = 1 instance.
        do_req(0, 1'b0, 3'd2, 32'h4b0, 32'd0,         1'b0, 1'b1, 32'h0000_0bb8, 1'b0, 1'b1);
        do_req(0, 1'b1, 3'd0, 32'h4b1, 32'h1234_5680, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1);
        do_req(0, 1'b0, 3'd0, 32'h4b1, 32'd0,         1'b0, 1'b1, 32'hffff_ff80, 1'b0, 1'b1);
        do_req(0, 1'b0, 3'd4, 32'h4b1, 32'd0,         1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
        do_req(0, 1'b0, 3'd2, 32'h4b0, 32'd0,         1'b0, 1'b1, 32'h0000_80b8, 1'b0, 1'b1);
        do_req(0, 1'b0, 3'd1, 32'h4b0, 32'd0,         1'b0, 1'b1, 32'hffff_80b8, 1'b0, 1'b1);
        do_req(0, 1'b1, 3'd1, 32'h016, 32'haaaa_7fff, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1);
        do_req(0, 1'b0, 3'd2, 32'h014, 32'd0,         1'b0, 1'b1, 32'h7fff_0032, 1'b0, 1'b1);
        do_req(0, 1'b0, 3'd5, 32'h016, 32'd0,         1'b0, 1'b1, 32'h0000_7fff, 1'b0, 1'b1);
        do_req(0, 1'b0, 3'd2, 32'h4b2, 32'd0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b1);
        do_req(0, 1'b0, 3'd1, 32'h4b1, 32'd0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b1);
        do_req(0, 1'b0, 3'd2, 32'h1000, 32'd0,        1'b0, 1'b1, 32'h0,         1'b1, 1'b1);
        do_req(0, 1'b0, 3'd3, 32'h4b0, 32'd0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b1);
        do_req(0, 1'b1, 3'd4, 32'h4b0, 32'h0000_00ff, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1);
        do_req(0, 1'b0, 3'd2, 32'h4b0, 32'd0,         1'b0, 1'b1, 32'h0000_80b8, 1'b0, 1'b1);
        for (int i = 0; i < 120; i++) rand_req(0);
        drain();

        // Abort a store on the WAIT_CYCLES = 3 instance during its second BUSY cycle.
        do_req(1, 1'b1, 3'd2, 32'h020, 32'hdead_beef, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        #1;
        check("abort_ready", {31'd0, req_ready[1]}, 32'd1);
        check("abort_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("abort_rsp_err", {31'd0, rsp_err[1]}, 32'd0);
        check("abort_rsp_rdata", rsp_rdata[1], 32'd0);
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        do_req(1, 1'b0, 3'd2, 32'h020, 32'd0, 1'b0, 1'b1, 32'h0000_0050, 1'b0, 1'b1);
        drain();

        // Back-to-back loads with req_valid held high throughout.
        do_req(1, 1'b0, 3'd2, 32'h004, 32'd0, 1'b1, 1'b1, 32'h0000_000a, 1'b0, 1'b1);
        a0 = acc_cyc;
        do_req(1, 1'b0, 3'd2, 32'h008, 32'd0, 1'b1, 1'b1, 32'h0000_0014, 1'b0, 1'b1);
        check("accept_spacing_1", 32'(acc_cyc - a0), 32'(wc[1] + 3));
        a0 = acc_cyc;
        do_req(1, 1'b0, 3'd2, 32'h004, 32'd0, 1'b0, 1'b1, 32'h0000_000a, 1'b0, 1'b1);
        check("accept_spacing_2", 32'(acc_cyc - a0), 32'(wc[1] + 3));
        for (int i = 0; i < 60; i++) rand_req(1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
